// File: rtl/vga_pkg.sv
// vga_pkg: tty control bytes and write-queue FSM state encoding shared by the vga clk-domain blocks
package vga_pkg;
  localparam logic [7:0] TTY_CR = 8'h0D;
  localparam logic [7:0] TTY_LF = 8'h0A;
  typedef enum logic [1:0] {IDLE, SEND, GUARD} tty_state_t;
endpackage

// File: rtl/vga_sync_fifo.sv
// vga_sync_fifo: synchronous fifo (clk, reset, push/wdata in, pop in, rdata/count/full/empty out); ignores push when full and pop when empty
module vga_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (DEPTH_LOG2 + 1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + DEPTH_LOG2'(do_push);
      rd_ptr <= rd_ptr + DEPTH_LOG2'(do_pop);
      count <= count + (DEPTH_LOG2 + 1)'(do_push) - (DEPTH_LOG2 + 1)'(do_pop);
    end
  end
endmodule

// File: rtl/vga_tty_write_queue.sv
// vga_tty_write_queue: byte queue (in_valid/in_data/in_ready) draining one strobe at a time to the console tty port (tty_write/tty_data/tty_busy), optional LF->CR LF, reports count/empty
module vga_tty_write_queue
  import vga_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter bit CRLF_EXPAND = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                tty_write,
  output logic [7:0]          tty_data,
  input  logic                tty_busy,
  output logic [DEPTH_LOG2:0] count,
  output logic                empty
);
  tty_state_t state;
  logic cr_sent, full, send_cr, pop;
  logic [7:0] head;
  assign in_ready = !full;
  assign send_cr = CRLF_EXPAND && head == TTY_LF && !cr_sent;
  assign pop = state == SEND && !send_cr;
  vga_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(in_valid),
    .wdata(in_data),
    .pop(pop),
    .rdata(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tty_write <= 1'b0;
      tty_data <= 8'h00;
      cr_sent <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tty_write <= 1'b0;
          state <= (!empty && !tty_busy) ? SEND : IDLE;
        end
        SEND: begin
          tty_write <= 1'b1;
          tty_data <= send_cr ? TTY_CR : head;
          cr_sent <= send_cr;
          state <= GUARD;
        end
        default: begin
          tty_write <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vga_tty_write_queue.sv
// tb_vga_tty_write_queue: directed scoreboard bench for the tty write queue with a busy-holding console model
module tb_vga_tty_write_queue;
  import vga_pkg::*;
  logic clk = 0, reset = 1, in_valid = 0, in_valid1 = 0, dual = 0;
  logic hold_busy = 1, model_busy = 0, console_on = 0, tty_busy;
  logic [7:0] in_data = 0;
  logic in_ready, tty_write, empty, in_ready1, tty_write1, empty1;
  logic [7:0] tty_data, tty_data1;
  logic [4:0] count, count1;
  logic b1 = 0, b2 = 0;
  int cyc = 0, n_vec = 0, n_err = 0, n_strobe = 0, last_cyc = 0, acc_cyc = 0;
  logic [7:0] exp_q[$], got1[$];
  int sc_q[$];
  assign tty_busy = hold_busy | model_busy;
  vga_tty_write_queue #(.DEPTH_LOG2(4), .CRLF_EXPAND(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .tty_write(tty_write), .tty_data(tty_data), .tty_busy(tty_busy), .count(count), .empty(empty)
  );
  vga_tty_write_queue #(.DEPTH_LOG2(4), .CRLF_EXPAND(1'b0)) dut_raw (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_data(in_data), .in_ready(in_ready1),
    .tty_write(tty_write1), .tty_data(tty_data1), .tty_busy(tty_busy), .count(count1), .empty(empty1)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    b1 <= tty_busy;
    b2 <= b1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  always @(negedge clk) begin
    if (tty_write) begin
      n_strobe++;
      last_cyc = cyc;
      sc_q.push_back(cyc);
      chk("busy_at_issue", {31'b0, b2}, 0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL unexpected_strobe observed=%0h expected=none", tty_data);
      end else chk("tty_data", {24'b0, tty_data}, {24'b0, exp_q.pop_front()});
    end
    if (tty_write1) got1.push_back(tty_data1);
  end
  initial forever begin
    @(negedge clk);
    if (console_on && tty_write) begin
      model_busy = 1;
      repeat (10) @(negedge clk);
      model_busy = 0;
    end
  end
  task automatic push(input logic [7:0] b, output bit ok);
    @(negedge clk);
    in_valid = 1;
    in_valid1 = dual;
    in_data = b;
    ok = in_ready;
    @(posedge clk);
    #1;
    if (ok) begin
      acc_cyc = cyc;
      if (b == TTY_LF) exp_q.push_back(TTY_CR);
      exp_q.push_back(b);
    end
  endtask
  task automatic stop();
    @(negedge clk);
    in_valid = 0;
    in_valid1 = 0;
  endtask
  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("drain_left", exp_q.size(), 0);
    chk("drain_count", {27'b0, count}, 0);
  endtask
  initial begin
    bit ok;
    int s0;
    logic [7:0] b;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk("rst_count", {27'b0, count}, 0);
    chk("rst_empty", {31'b0, empty}, 1);
    chk("rst_ready", {31'b0, in_ready}, 1);
    chk("rst_write", {31'b0, tty_write}, 0);
    chk("rst_data", {24'b0, tty_data}, 0);
    for (int i = 0; i < 3; i++) push(8'h61 + 8'(i), ok);
    stop();
    chk("t1_count3", {27'b0, count}, 3);
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
    exp_q.delete();
    hold_busy = 0;
    s0 = n_strobe;
    chk("t1_count", {27'b0, count}, 0);
    chk("t1_empty", {31'b0, empty}, 1);
    chk("t1_ready", {31'b0, in_ready}, 1);
    chk("t1_write", {31'b0, tty_write}, 0);
    repeat (20) @(negedge clk);
    chk("t1_no_strobe", n_strobe, s0);
    s0 = n_strobe;
    push(8'h41, ok);
    stop();
    repeat (10) @(negedge clk);
    chk("t2_strobes", n_strobe - s0, 1);
    chk("t2_latency", last_cyc - acc_cyc, 2);
    chk("t2_count", {27'b0, count}, 0);
    sc_q.delete();
    got1.delete();
    dual = 1;
    push(8'h48, ok);
    push(TTY_LF, ok);
    push(8'h49, ok);
    stop();
    dual = 0;
    repeat (25) @(negedge clk);
    chk("t3_strobes", sc_q.size(), 4);
    for (int i = 1; i < 4; i++) chk("t3_spacing", sc_q[i] - sc_q[i-1], 3);
    chk("t3_raw_n", got1.size(), 3);
    chk("t3_raw0", {24'b0, got1[0]}, 32'h48);
    chk("t3_raw1", {24'b0, got1[1]}, 32'h0A);
    chk("t3_raw2", {24'b0, got1[2]}, 32'h49);
    hold_busy = 1;
    for (int i = 0; i < 16; i++) begin
      push(8'h80 + 8'(i), ok);
      chk("t4_accept", {31'b0, ok}, 1);
    end
    push(8'hEE, ok);
    chk("t4_reject17", {31'b0, ok}, 0);
    stop();
    chk("t4_count16", {27'b0, count}, 16);
    chk("t4_ready0", {31'b0, in_ready}, 0);
    hold_busy = 0;
    for (int i = 0; i < 50 && !tty_write; i++) @(negedge clk);
    chk("t4_first_pop", {31'b0, tty_write}, 1);
    chk("t4_ready1", {31'b0, in_ready}, 1);
    chk("t4_count15", {27'b0, count}, 15);
    drain(200);
    console_on = 1;
    for (int i = 0; i < 100; i++) begin
      b = (i % 7 == 3) ? TTY_LF : 8'($urandom_range(0, 255));
      ok = 0;
      for (int k = 0; k < 100 && !ok; k++) push(b, ok);
      chk("t5_accept", {31'b0, ok}, 1);
    end
    stop();
    drain(5000);
    console_on = 0;
    repeat (12) @(negedge clk);
    hold_busy = 1;
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i), ok);
    stop();
    chk("t6_count5", {27'b0, count}, 5);
    @(negedge clk) hold_busy = 0;
    push(8'h35, ok);
    stop();
    hold_busy = 1;
    chk("t6_pushpop_write", {31'b0, tty_write}, 1);
    chk("t6_pushpop_count", {27'b0, count}, 5);
    hold_busy = 0;
    drain(200);
    push(TTY_LF, ok);
    stop();
    for (int i = 0; i < 30 && !(tty_write && tty_data == TTY_CR); i++) @(negedge clk);
    chk("t6_cr_seen", {24'b0, tty_data}, {24'b0, TTY_CR});
    reset = 1;
    @(negedge clk) reset = 0;
    exp_q.delete();
    s0 = n_strobe;
    chk("t6_rst_count", {27'b0, count}, 0);
    chk("t6_rst_empty", {31'b0, empty}, 1);
    repeat (20) @(negedge clk);
    chk("t6_no_lf", n_strobe, s0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
